// File: rtl/vx_cache_req_bank_dispatch_pkg.sv
// Shared sizing helpers for the multi-cycle core-request bank dispatcher.
// Bank-select offset/width, lane-index width and power-of-two checks.
package vx_cache_req_bank_dispatch_pkg;

    // Index width that stays at least 1 bit even for a single lane/bank.
    function automatic int riw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

    // Word offset of the bank-select field inside a word address.
    function automatic int word_off(input int line_size, input int word_size);
        return $clog2(line_size / word_size);
    endfunction

endpackage

// File: rtl/vx_cache_req_bank_dispatch_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
// Purely combinational; the owner keeps and advances the pointer.
module vx_cache_req_bank_dispatch_rr_arbiter
    import vx_cache_req_bank_dispatch_pkg::*;
#(
    parameter int NUM_REQS = 4
) (
    input  logic [NUM_REQS-1:0]               requests,
    input  logic [riw_of(NUM_REQS)-1:0]       ptr,
    output logic [NUM_REQS-1:0]               grant_onehot,
    output logic [riw_of(NUM_REQS)-1:0]       grant_idx,
    output logic                              grant_valid
);
    localparam int RIW = riw_of(NUM_REQS);

    int unsigned scan_idx;
    logic        found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        scan_idx     = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            scan_idx = (int'(ptr) + k) % NUM_REQS;
            if (!found && requests[scan_idx]) begin
                found                  = 1'b1;
                grant_onehot[scan_idx] = 1'b1;
                grant_idx              = RIW'(scan_idx);
            end
        end
    end

    assign grant_valid = |requests;

endmodule

// File: rtl/vx_cache_req_bank_dispatch.sv
// Spreads a batch of core word requests over the banks, resolving conflicts
// over several cycles. Optional conflict-stall counter: VX_CACHE_BANK_CONFLICT_PERF_EN.
module vx_cache_req_bank_dispatch
    import vx_cache_req_bank_dispatch_pkg::*;
#(
    parameter int BANK_LINE_SIZE  = 16,
    parameter int WORD_SIZE       = 4,
    parameter int NUM_BANKS       = 4,
    parameter int NUM_REQUESTS    = 4,
    parameter int WORD_ADDR_WIDTH = 30,
    parameter int PERF_CTR_BITS   = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NUM_REQUESTS-1:0]                   core_req_valid,
    input  logic [NUM_REQUESTS*WORD_ADDR_WIDTH-1:0]   core_req_addr,
    output logic                                      core_req_ready,
    output logic [NUM_BANKS-1:0]                      per_bank_valid,
    output logic [NUM_BANKS*riw_of(NUM_REQUESTS)-1:0] per_bank_req_idx,
    input  logic [NUM_BANKS-1:0]                      per_bank_ready
`ifdef VX_CACHE_BANK_CONFLICT_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]                  perf_conflict_stalls
`endif
);
    localparam int RIW  = riw_of(NUM_REQUESTS);
    localparam int BSW  = riw_of(NUM_BANKS);
    localparam int WOFF = word_off(BANK_LINE_SIZE, WORD_SIZE);

    logic                    batch_active_q, batch_active_d;
    logic [NUM_REQUESTS-1:0] pending_q, pending_d;
    logic [NUM_REQUESTS-1:0] cand, remaining, fired_lanes;
    logic [BSW-1:0]          bank_sel [NUM_REQUESTS];
    logic [NUM_REQUESTS-1:0] bank_fired_oh [NUM_BANKS];
    logic [NUM_BANKS-1:0]    bank_fire;

    // Mid-batch only the leftover lanes compete; fired lanes never return.
    assign cand = batch_active_q ? pending_q : core_req_valid;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQUESTS; gi++) begin : g_lane
            if (NUM_BANKS == 1) begin : g_single
                assign bank_sel[gi] = '0;
            end else begin : g_multi
                assign bank_sel[gi] = core_req_addr[gi*WORD_ADDR_WIDTH + WOFF +: BSW];
            end
        end

        for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            logic [NUM_REQUESTS-1:0] req;
            logic [NUM_REQUESTS-1:0] grant_oh;
            logic [RIW-1:0]          grant_idx;
            logic                    grant_valid;
            logic [RIW-1:0]          rr_ptr_q, rr_ptr_d;

            always_comb begin
                req = '0;
                for (int i = 0; i < NUM_REQUESTS; i++) begin
                    req[i] = cand[i] && (int'(bank_sel[i]) == gi);
                end
            end

            vx_cache_req_bank_dispatch_rr_arbiter #(
                .NUM_REQS     (NUM_REQUESTS)
            ) u_arb (
                .requests     (req),
                .ptr          (rr_ptr_q),
                .grant_onehot (grant_oh),
                .grant_idx    (grant_idx),
                .grant_valid  (grant_valid)
            );

            // Outputs are forced quiet for as long as reset is held.
            assign per_bank_valid[gi]              = grant_valid & ~reset;
            assign per_bank_req_idx[gi*RIW +: RIW] = reset ? '0 : grant_idx;
            assign bank_fire[gi]     = per_bank_valid[gi] & per_bank_ready[gi];
            assign bank_fired_oh[gi] = bank_fire[gi] ? grant_oh : '0;
            assign rr_ptr_d          = RIW'((int'(grant_idx) + 1) % NUM_REQUESTS);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rr_ptr_q <= '0;
                end else if (bank_fire[gi]) begin
                    rr_ptr_q <= rr_ptr_d;
                end
            end
        end
    endgenerate

    always_comb begin
        fired_lanes = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            fired_lanes = fired_lanes | bank_fired_oh[b];
        end
    end

    assign remaining      = cand & ~fired_lanes;
    assign core_req_ready = ~reset & (remaining == '0);
    assign batch_active_d = |remaining;
    assign pending_d      = remaining;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            batch_active_q <= 1'b0;
            pending_q      <= '0;
        end else begin
            batch_active_q <= batch_active_d;
            pending_q      <= pending_d;
        end
    end

`ifdef VX_CACHE_BANK_CONFLICT_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_stalls_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stalls_q <= '0;
        end else if ((|core_req_valid) && !core_req_ready && !(&perf_stalls_q)) begin
            perf_stalls_q <= perf_stalls_q + PERF_CTR_BITS'(1);
        end
    end

    assign perf_conflict_stalls = perf_stalls_q;
`endif

endmodule
